// File: rtl/krnl_rtl_trial_a_example_number_checker.sv
// AXI4-Stream sink checking the incrementing-number pattern (lane k of beat b = b*N+k mod 2^W).
// Optional producer-stall exercise: define KRNL_RTL_TRIAL_A_EXAMPLE_NUMBER_CHECKER_BACKPRESSURE_EN.
//
// state | meaning
// IDLE  | waiting for a rising edge on ap_start; tready low
// RUN   | accepting and checking beats until the last beat (index NB-1 or tlast)
module krnl_rtl_trial_a_example_number_checker #(
   parameter int C_S_AXIS_TDATA_WIDTH = 128,
   parameter int C_NUMBER_BIT_WIDTH   = 32,
   parameter int C_LENGTH_IN_BYTES    = 16384
) (
   input  logic                              aclk,
   input  logic                              areset_n,
   input  logic                              ap_start,
   output logic                              ap_done,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                              s_axis_tlast,
   output logic [15:0]                       error_count,
   output logic                              pass
);

   localparam int W   = (C_NUMBER_BIT_WIDTH > C_S_AXIS_TDATA_WIDTH) ? C_S_AXIS_TDATA_WIDTH
                                                                    : C_NUMBER_BIT_WIDTH;
   localparam int N   = C_S_AXIS_TDATA_WIDTH / W;
   localparam int KB  = W / 8;
   localparam int BPB = C_S_AXIS_TDATA_WIDTH / 8;
   localparam int NB  = (C_LENGTH_IN_BYTES + BPB - 1) / BPB;
   localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
   localparam int REM = C_LENGTH_IN_BYTES % BPB;

   localparam logic [BPB-1:0] FULL_KEEP = '1;
   localparam logic [BPB-1:0] LAST_KEEP = (REM == 0) ? FULL_KEEP
                                                     : ((BPB'(1) << REM) - BPB'(1));
   localparam logic [CW-1:0]  LAST_BEAT = CW'(NB - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic            ap_start_r;
   logic [CW-1:0]   beat_cnt;
   logic [W-1:0]    base;

   logic            go;
   logic            accept;
   logic            is_last_idx;
   logic            final_beat;
   logic            data_err;
   logic            beat_err;
   logic [BPB-1:0]  exp_keep;
   logic [W-1:0]    lane_exp;
   logic [15:0]     err_next;

   // base tracks b*N so each lane's expectation is just base+k, wrapping at 2^W
   always_comb begin
      go          = ap_start & ~ap_start_r;
      accept      = s_axis_tvalid & s_axis_tready & (state == RUN);
      is_last_idx = (beat_cnt == LAST_BEAT);
      exp_keep    = is_last_idx ? LAST_KEEP : FULL_KEEP;
      data_err    = 1'b0;
      lane_exp    = '0;
      for (int k = 0; k < N; k++) begin
         lane_exp = base + W'(k);
         if ((&s_axis_tkeep[k*KB +: KB]) && (s_axis_tdata[k*W +: W] != lane_exp))
            data_err = 1'b1;
      end
      beat_err    = data_err | (s_axis_tkeep != exp_keep) | (s_axis_tlast != is_last_idx);
      err_next    = (beat_err && (error_count != 16'hFFFF)) ? error_count + 16'd1
                                                            : error_count;
      final_beat  = accept & (is_last_idx | s_axis_tlast);
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         state         <= IDLE;
         ap_start_r    <= 1'b0;
         ap_done       <= 1'b0;
         s_axis_tready <= 1'b0;
         error_count   <= '0;
         pass          <= 1'b0;
         beat_cnt      <= '0;
         base          <= '0;
      end else begin
         ap_start_r <= ap_start;
         ap_done    <= 1'b0;
         case (state)
            IDLE: begin
               s_axis_tready <= 1'b0;
               if (go) begin
                  state         <= RUN;
                  s_axis_tready <= 1'b1;
                  beat_cnt      <= '0;
                  base          <= '0;
                  error_count   <= '0;
                  pass          <= 1'b0;
               end
            end
            RUN: begin
`ifdef KRNL_RTL_TRIAL_A_EXAMPLE_NUMBER_CHECKER_BACKPRESSURE_EN
               s_axis_tready <= ~s_axis_tready;
`else
               s_axis_tready <= 1'b1;
`endif
               if (accept) begin
                  error_count <= err_next;
                  beat_cnt    <= beat_cnt + CW'(1);
                  base        <= base + W'(N);
                  if (final_beat) begin
                     state         <= IDLE;
                     s_axis_tready <= 1'b0;
                     ap_done       <= 1'b1;
                     pass          <= (err_next == 16'd0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_krnl_rtl_trial_a_example_number_checker.sv
// Scoreboard bench for the number checker: default-length instance (a) and a 16380-byte instance (b).
module tb_krnl_rtl_trial_a_example_number_checker;

   logic         clk = 1'b0;
   logic         areset_n;
   logic         start_a, start_b;
   logic         tvalid, tlast;
   logic [127:0] tdata;
   logic [15:0]  tkeep;
   logic         done_a, ready_a, pass_a;
   logic         done_b, ready_b, pass_b;
   logic [15:0]  err_a, err_b;

   typedef struct {int err; int pas;} exp_t;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t mon_e;

   int checks     = 0;
   int errors     = 0;
   int done_seen  = 0;
   int done_exp   = 0;

   always #5 clk = ~clk;

   krnl_rtl_trial_a_example_number_checker u_dut_a (
      .aclk(clk), .areset_n(areset_n), .ap_start(start_a), .ap_done(done_a),
      .s_axis_tvalid(tvalid), .s_axis_tready(ready_a), .s_axis_tdata(tdata),
      .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .error_count(err_a), .pass(pass_a)
   );

   krnl_rtl_trial_a_example_number_checker #(.C_LENGTH_IN_BYTES(16380)) u_dut_b (
      .aclk(clk), .areset_n(areset_n), .ap_start(start_b), .ap_done(done_b),
      .s_axis_tvalid(tvalid), .s_axis_tready(ready_b), .s_axis_tdata(tdata),
      .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .error_count(err_b), .pass(pass_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rdy(input int sel);
      return sel != 0 ? 32'(ready_b) : 32'(ready_a);
   endfunction
   function automatic logic [31:0] dn(input int sel);
      return sel != 0 ? 32'(done_b) : 32'(done_a);
   endfunction
   function automatic logic [31:0] errc(input int sel);
      return sel != 0 ? 32'(err_b) : 32'(err_a);
   endfunction
   function automatic logic [31:0] pas(input int sel);
      return sel != 0 ? 32'(pass_b) : 32'(pass_a);
   endfunction

   function automatic logic [127:0] clean(input int b);
      logic [127:0] d;
      for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'(b*4 + k);
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel != 0) start_b = v; else start_a = v;
   endtask

   task automatic start_run(input int sel);
      set_start(sel, 1'b1);
      tick();
      check("tready_after_go", rdy(sel), 32'd1);
      set_start(sel, 1'b0);
   endtask

   task automatic send_beat(input int sel, input logic [127:0] d, input logic [15:0] k,
                            input logic l, input bit gaps);
      int waited;
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      tdata  = d;
      tkeep  = k;
      tlast  = l;
      tvalid = 1'b1;
      waited = 0;
      while (rdy(sel) != 32'd1 && waited < 100) begin
         tick();
         waited++;
      end
      if (waited >= 100) check("accept_timeout", 32'(waited), 32'd0);
      tick();
      tvalid = 1'b0;
   endtask

   // Expected per-beat error count is rebuilt from the injected faults; run totals are constants.
   task automatic run(input int sel, input int nb_total, input logic [15:0] last_keep,
                      input bit final_bad, input bit junk3, input int bad_lane,
                      input int bad_keep, input int early, input int abort_at,
                      input int go_poke, input bit gaps, input int exp_total, input bit exp_pass);
      int final_b, n_send, exp_run;
      logic [127:0] d;
      logic [15:0]  k;
      logic         l;
      bit           inj;
      exp_t         e;
      final_b = (early >= 0) ? early : nb_total - 1;
      n_send  = (abort_at >= 0) ? abort_at : final_b + 1;
      if (abort_at < 0) begin
         e.err = exp_total;
         e.pas = int'(exp_pass);
         if (sel != 0) q_b.push_back(e); else q_a.push_back(e);
         done_exp++;
      end
      exp_run = 0;
      for (int b = 0; b < n_send; b++) begin
         d   = clean(b);
         k   = 16'hFFFF;
         l   = (b == nb_total - 1);
         inj = 1'b0;
         if (b == nb_total - 1) begin
            k = last_keep;
            if (junk3) d[127:96] = 32'hDEAD_BEEF;
            inj = final_bad;
         end
         if (b == bad_lane) begin
            d[95:64] = d[95:64] + 32'd1;
            inj = 1'b1;
         end
         if (b == bad_keep) begin
            k = 16'hFFF0;
            inj = 1'b1;
         end
         if (b == early) begin
            l = 1'b1;
            if (b != nb_total - 1) inj = 1'b1;
         end
         if (b == go_poke) set_start(sel, 1'b1);
         if (b == go_poke + 1) set_start(sel, 1'b0);
         send_beat(sel, d, k, l, gaps);
         if (inj) exp_run++;
         check("beat_error_count", errc(sel), 32'(exp_run));
      end
      if (abort_at < 0) begin
         check("done_pulse", dn(sel), 32'd1);
         check("tready_low_after_last", rdy(sel), 32'd0);
         tick();
         check("done_one_cycle", dn(sel), 32'd0);
         check("tready_stays_low", rdy(sel), 32'd0);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (done_a === 1'b1) begin
            done_seen++;
            if (q_a.size() == 0) check("unexpected_done_a", 32'd1, 32'd0);
            else begin
               mon_e = q_a.pop_front();
               check("sb_error_count_a", 32'(err_a), 32'(mon_e.err));
               check("sb_pass_a", 32'(pass_a), 32'(mon_e.pas));
            end
         end
         if (done_b === 1'b1) begin
            done_seen++;
            if (q_b.size() == 0) check("unexpected_done_b", 32'd1, 32'd0);
            else begin
               mon_e = q_b.pop_front();
               check("sb_error_count_b", 32'(err_b), 32'(mon_e.err));
               check("sb_pass_b", 32'(pass_b), 32'(mon_e.pas));
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      areset_n = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      tvalid   = 1'b0;
      tlast    = 1'b0;
      tdata    = '0;
      tkeep    = '0;
      repeat (5) tick();
      for (int s = 0; s < 2; s++) begin
         check("reset_done", dn(s), 32'd0);
         check("reset_tready", rdy(s), 32'd0);
         check("reset_error_count", errc(s), 32'd0);
         check("reset_pass", pas(s), 32'd0);
      end

      // go coincident with reset must not start a run
      start_a = 1'b1;
      tick();
      check("go_in_reset_ignored", rdy(0), 32'd0);
      start_a = 1'b0;
      tick();
      areset_n = 1'b1;
      tick();
      tvalid = 1'b1;
      tick();
      check("idle_not_ready", rdy(0), 32'd0);
      tick();
      check("idle_not_ready_b", rdy(1), 32'd0);
      tvalid = 1'b0;

      // clean run with a second go mid-run, which must be ignored
      start_run(0);
      run(0, 1024, 16'hFFFF, 0, 0, -1, -1, -1, -1, 300, 0, 0, 1);
      check("clean_pass", pas(0), 32'd1);

      start_run(0);
      run(0, 1024, 16'hFFFF, 0, 0, 5, 9, -1, -1, -1, 0, 2, 0);

      start_run(0);
      run(0, 1024, 16'hFFFF, 0, 0, -1, -1, 100, -1, -1, 0, 1, 0);
      repeat (3) tick();
      check("early_tready_idle", rdy(0), 32'd0);

      start_run(1);
      run(1, 1024, 16'h0FFF, 0, 1, -1, -1, -1, -1, -1, 0, 0, 1);
      start_run(1);
      run(1, 1024, 16'hFFFF, 1, 1, -1, -1, -1, -1, -1, 0, 1, 0);

      // partial run with gaps, aborted by reset at beat 500
      start_run(0);
      run(0, 1024, 16'hFFFF, 0, 0, 10, -1, -1, 500, -1, 1, 0, 0);
      areset_n = 1'b0;
      tick();
      check("midrun_reset_done", dn(0), 32'd0);
      check("midrun_reset_tready", rdy(0), 32'd0);
      check("midrun_reset_error_count", errc(0), 32'd0);
      check("midrun_reset_pass", pas(0), 32'd0);
      areset_n = 1'b1;
      tick();

      start_run(0);
      tick();
`ifdef KRNL_RTL_TRIAL_A_EXAMPLE_NUMBER_CHECKER_BACKPRESSURE_EN
      check("tready_toggle_low", rdy(0), 32'd0);
`else
      check("tready_steady_high", rdy(0), 32'd1);
`endif
      tick();
      check("tready_high_again", rdy(0), 32'd1);
      run(0, 1024, 16'hFFFF, 0, 0, -1, -1, -1, -1, -1, 1, 0, 1);

      repeat (3) tick();
      check("done_count", 32'(done_seen), 32'(done_exp));
      check("scoreboard_a_empty", 32'(q_a.size()), 32'd0);
      check("scoreboard_b_empty", 32'(q_b.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
